// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Function : 32-bit UART receiver. 8N1-style framing widened to 32 data bits,
//             LSB first, 2-flop input synchroniser, mid-bit sampling.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_line,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int BAUD_TICKS = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam int TICK_W     = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;

    localparam logic [TICK_W-1:0] c_baud_last = TICK_W'(BAUD_TICKS - 1);
    localparam logic [TICK_W-1:0] c_half_last = TICK_W'(HALF_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_rx_meta;
    logic               r_rx_s;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [5:0]         r_bit_cnt;
    logic [31:0]        r_shift;

    // Synchroniser resets to the idle-high line level so reset release is not
    // mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_line;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == c_half_last) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == c_baud_last) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[31:1]};
                        r_bit_cnt  <= r_bit_cnt + 6'd1;
                        if (r_bit_cnt == 6'd31) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick_cnt == c_baud_last) begin
                        r_tick_cnt <= '0;
                        if (r_rx_s) begin
                            data_out   <= r_shift;
                            data_valid <= 1'b1;
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A line stuck low must not look like a fresh start bit.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Function : Directed self-checking bench for uart_rx (16 clocks per bit),
//             plus a default-parameter loopback from a bench-side serialiser.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int BT      = 16;
    localparam int BT_DEF  = 100_000_000 / 115200;

    logic        clk;
    logic        rst_n;
    logic        rx_line;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    logic        rx_line2;
    logic [31:0] data_out2;
    logic        data_valid2;
    logic        frame_err2;
    logic        busy2;

    int          n_cmp;
    int          n_err;
    int          cyc;
    int          dv_cnt;
    int          fe_cnt;
    int          both_cnt;
    int          dv2_cnt;
    int          t_fall;
    int          dv_time [$];
    logic [31:0] dv_data [$];

    uart_rx #(.CLK_FREQ_HZ(16), .BAUD_RATE(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_line    (rx_line),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    uart_rx u_dut_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_line    (rx_line2),
        .data_out   (data_out2),
        .data_valid (data_valid2),
        .frame_err  (frame_err2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_time.push_back(cyc);
            dv_data.push_back(data_out);
        end
        if (frame_err)               fe_cnt   <= fe_cnt + 1;
        if (data_valid && frame_err) both_cnt <= both_cnt + 1;
        if (data_valid2)             dv2_cnt  <= dv2_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_line = b;
        wait_cycles(BT);
    endtask

    task automatic send_frame(input logic [31:0] w, input logic stop);
        t_fall = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 32; i++) drive_bit(w[i]);
        drive_bit(stop);
    endtask

    task automatic send_frame_def(input logic [31:0] w);
        rx_line2 = 1'b0;
        wait_cycles(BT_DEF);
        for (int i = 0; i < 32; i++) begin
            rx_line2 = w[i];
            wait_cycles(BT_DEF);
        end
        rx_line2 = 1'b1;
        wait_cycles(BT_DEF);
    endtask

    int dv0, fe0;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        dv_cnt = 0; fe_cnt = 0; both_cnt = 0; dv2_cnt = 0; t_fall = 0;
        rst_n = 1'b0; rx_line = 1'b1; rx_line2 = 1'b1;
        wait_cycles(3);

        check("rst_data_out",   data_out,   32'h0);
        check("rst_data_valid", {31'b0, data_valid}, 32'h0);
        check("rst_frame_err",  {31'b0, frame_err},  32'h0);
        check("rst_busy",       {31'b0, busy},       32'h0);
        rst_n = 1'b1;
        wait_cycles(4);
        check("post_rst_busy", {31'b0, busy}, 32'h0);

        // Good frame, with latency measured from the line falling edge.
        dv0 = dv_cnt; fe0 = fe_cnt;
        fork
            send_frame(32'hA5A5_0F3C, 1'b1);
            begin
                wait_cycles(40);
                check("busy_mid_frame", {31'b0, busy}, 32'h1);
            end
        join
        wait_cycles(8);
        check("good_dv_count", dv_cnt - dv0, 1);
        check("good_fe_count", fe_cnt - fe0, 0);
        check("good_data", data_out, 32'hA5A5_0F3C);
        if (dv_time.size() >= 1)
            check("good_latency_ok",
                  ((dv_time[0] - t_fall) >= 538 && (dv_time[0] - t_fall) <= 540) ? 32'h1 : 32'h0, 32'h1);
        else
            check("good_latency_pulse", 32'h0, 32'h1);
        check("good_busy_after", {31'b0, busy}, 32'h0);

        // Short glitch is rejected at the mid-start sample.
        dv0 = dv_cnt; fe0 = fe_cnt;
        rx_line = 1'b0;
        wait_cycles(4);
        rx_line = 1'b1;
        wait_cycles(3);
        check("glitch_busy_during", {31'b0, busy}, 32'h1);
        wait_cycles(20);
        check("glitch_busy", {31'b0, busy}, 32'h0);
        check("glitch_pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);

        // Bad stop bit, line then held low.
        dv0 = dv_cnt; fe0 = fe_cnt;
        send_frame(32'h1234_5678, 1'b0);
        rx_line = 1'b0;
        wait_cycles(40);
        check("ferr_fe_count", fe_cnt - fe0, 1);
        check("ferr_dv_count", dv_cnt - dv0, 0);
        check("ferr_data_kept", data_out, 32'hA5A5_0F3C);
        check("ferr_busy_held_low", {31'b0, busy}, 32'h1);
        rx_line = 1'b1;
        wait_cycles(20);
        check("ferr_busy_released", {31'b0, busy}, 32'h0);
        check("ferr_fe_still_one", fe_cnt - fe0, 1);

        // Back-to-back frames.
        dv0 = dv_cnt;
        send_frame(32'hFFFF_FFFF, 1'b1);
        send_frame(32'h0000_0001, 1'b1);
        wait_cycles(8);
        check("b2b_dv_count", dv_cnt - dv0, 2);
        if (dv_data.size() >= 3) begin
            check("b2b_first",   dv_data[1], 32'hFFFF_FFFF);
            check("b2b_second",  dv_data[2], 32'h0000_0001);
            check("b2b_spacing", dv_time[2] - dv_time[1], 34 * BT);
        end else begin
            check("b2b_pulses_seen", dv_data.size(), 3);
        end

        // Reset in the middle of data bit 10.
        rx_line = 1'b0;
        wait_cycles(BT);
        for (int i = 0; i < 10; i++) drive_bit(32'hDEAD_BEEF >> i);
        rx_line = 1'b1;
        wait_cycles(BT / 2);
        rst_n = 1'b0;
        wait_cycles(2);
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_busy",     {31'b0, busy}, 32'h0);
        check("midrst_dv_fe",    {30'b0, data_valid, frame_err}, 32'h0);
        dv0 = dv_cnt; fe0 = fe_cnt;
        rst_n = 1'b1;
        wait_cycles(600);
        check("midrst_no_pulses", (dv_cnt - dv0) + (fe_cnt - fe0), 0);
        send_frame(32'h0000_00FF, 1'b1);
        wait_cycles(8);
        check("midrst_next_dv", dv_cnt - dv0, 1);
        check("midrst_next_data", data_out, 32'h0000_00FF);

        check("never_both_pulses", both_cnt, 0);

        // Default-parameter loopback.
        send_frame_def(32'hCAFE_F00D);
        wait_cycles(20);
        check("loop_dv_count", dv2_cnt, 1);
        check("loop_data", data_out2, 32'hCAFE_F00D);
        check("loop_busy", {31'b0, busy2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
